// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM encoding, word size and SPI mode constants.
package spi_pkg;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned BIT_IDX_W = 3;
    localparam int unsigned DIV_CNT_W = 8;

    // Mode 0 framing: SCLK idles low, data shifted most-significant bit first.
    localparam logic CPOL      = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } spi_state_e;

    function automatic logic out_bit(input logic [WORD_W-1:0] b);
        return MSB_FIRST ? b[WORD_W-1] : b[0];
    endfunction

    function automatic logic [WORD_W-1:0] shift_out(input logic [WORD_W-1:0] b);
        return MSB_FIRST ? {b[WORD_W-2:0], 1'b0} : {1'b0, b[WORD_W-1:1]};
    endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// DIV-cycle terminal-count strobe; restart holds the count at zero so each phase starts aligned.
module spi_clkdiv
    import spi_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick_c
);

    localparam logic [DIV_CNT_W-1:0] TERM = DIV_CNT_W'(DIV - 1);

    logic [DIV_CNT_W-1:0] cnt_q;
    logic [DIV_CNT_W-1:0] cnt_d;

    always_comb begin
        tick_c = 1'b0;
        cnt_d  = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            tick_c = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + DIV_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master (mode 0, MSB first): shifts tx_data out on MOSI while
// assembling the MISO byte, then presents it on rx_data with a one-cycle done pulse.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              ss
);

    spi_state_e           state_q,   state_d;
    logic [WORD_W-1:0]    tx_q,      tx_d;
    logic [WORD_W-1:0]    rx_sh_q,   rx_sh_d;
    logic [WORD_W-1:0]    rx_data_q, rx_data_d;
    logic [BIT_IDX_W-1:0] bit_q,     bit_d;
    logic                 sclk_q,    sclk_d;
    logic                 mosi_q,    mosi_d;
    logic                 ss_q,      ss_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    logic restart_c;
    logic tick_c;

    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(WORD_W - 1);

    spi_clkdiv #(
        .DIV (DIV)
    ) u_clkdiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart_c),
        .tick_c  (tick_c)
    );

    // Next-state and output decode; each non-idle phase lasts one divider period.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_d      = ss_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        restart_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                restart_c = 1'b1;
                if (start) begin
                    tx_d    = tx_data;
                    rx_sh_d = '0;
                    bit_d   = '0;
                    busy_d  = 1'b1;
                    ss_d    = 1'b1;
                    mosi_d  = out_bit(tx_data);
                    state_d = ST_SETUP;
                end else begin
                    // SS may only be held or released here, never re-asserted.
                    ss_d = ss_q & hold;
                end
            end

            ST_SETUP: begin
                if (tick_c) begin
                    sclk_d  = ~CPOL;
                    state_d = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (tick_c) begin
                    sclk_d  = CPOL;
                    rx_sh_d = {rx_sh_q[WORD_W-2:0], miso};
                    if (bit_q != LAST_BIT) begin
                        tx_d    = shift_out(tx_q);
                        mosi_d  = out_bit(shift_out(tx_q));
                        bit_d   = bit_q + BIT_IDX_W'(1);
                        state_d = ST_LOW;
                    end else begin
                        rx_data_d = {rx_sh_q[WORD_W-2:0], miso};
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        ss_d      = hold;
                        state_d   = ST_IDLE;
                    end
                end
            end

            ST_LOW: begin
                if (tick_c) begin
                    sclk_d  = ~CPOL;
                    state_d = ST_HIGH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_q     <= '0;
            sclk_q    <= CPOL;
            mosi_q    <= 1'b0;
            ss_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_q      <= ss_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ss      = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a DIV=2 instance against a behavioural slave and a
// DIV=1 instance in loopback; expectations come from the transfer rules, not the RTL.
module tb_spi_master;

    localparam int unsigned DIV0 = 2;
    localparam int unsigned DIV1 = 1;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         t0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start0, hold0, busy0, done0, sclk0, mosi0, ss0;
    logic       miso0;
    logic [7:0] tx_data0, rx_data0;
    logic       start1, hold1, busy1, done1, sclk1, mosi1, ss1;
    logic [7:0] tx_data1, rx_data1;

    spi_master #(.DIV(DIV0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .tx_data(tx_data0), .hold(hold0),
        .busy(busy0), .done(done0), .rx_data(rx_data0), .sclk(sclk0), .mosi(mosi0),
        .miso(miso0), .ss(ss0)
    );

    spi_master #(.DIV(DIV1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .tx_data(tx_data1), .hold(hold1),
        .busy(busy1), .done(done1), .rx_data(rx_data1), .sclk(sclk1), .mosi(mosi1),
        .miso(mosi1), .ss(ss1)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Behavioural slave: captures MOSI on each SCLK rise and presents the next response bit.
    logic [7:0] resp_next = 8'h00;
    logic [7:0] s_resp;
    logic [7:0] s_rx = 8'h00;
    logic [2:0] s_idx;
    always @(posedge sclk0 or negedge rst_n) begin
        if (!rst_n) begin
            s_idx = 3'd0;
            miso0 = 1'b0;
        end else begin
            if (s_idx == 3'd0) s_resp = resp_next;
            s_rx  = {s_rx[6:0], mosi0};
            miso0 = s_resp[3'd7 - s_idx];
            s_idx = s_idx + 3'd1;
        end
    end

    // Monitor for the DIV=2 instance: SCLK shape, MOSI stability and the scoreboard pop.
    int   rises0 = 0;
    int   run0 = 0;
    int   done_cnt0 = 0;
    int   ss_low_cnt0 = 0;
    logic sclk_prev0 = 1'b0;
    logic mosi_prev0 = 1'b0;
    logic mosi_rise0 = 1'b0;
    bit   low_armed0 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            rises0     = 0;
            run0       = 0;
            low_armed0 = 1'b0;
            sclk_prev0 = 1'b0;
        end else begin
            if (!ss0) ss_low_cnt0++;
            if (sclk0 === sclk_prev0) begin
                run0++;
            end else begin
                if (sclk_prev0) begin
                    check("sclk_high_cycles", 32'(run0), 32'(DIV0));
                    check("mosi_stable_while_high", 32'(mosi_prev0), 32'(mosi_rise0));
                    low_armed0 = 1'b1;
                end else begin
                    if (low_armed0) check("sclk_low_cycles", 32'(run0), 32'(DIV0));
                    rises0++;
                    mosi_rise0 = mosi0;
                end
                run0 = 1;
            end
            sclk_prev0 = sclk0;
            mosi_prev0 = mosi0;
            if (done0) begin
                done_cnt0++;
                low_armed0 = 1'b0;
                if (q0.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done0: got done with rx_data 0x%0h, expected none", rx_data0);
                end else begin
                    e = q0.pop_front();
                    check("rx_data0", 32'(rx_data0), 32'(e.rx));
                    check("slave_captured", 32'(s_rx), 32'(e.tx));
                    check("latency0", 32'(cyc - e.t0), 32'(16 * DIV0 + 1));
                    check("sclk_pulses", 32'(rises0), 32'd8);
                end
                rises0 = 0;
            end
        end
    end

    // Monitor for the loopback DIV=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done1: got done with rx_data 0x%0h, expected none", rx_data1);
            end else begin
                e = q1.pop_front();
                check("rx_data1_loopback", 32'(rx_data1), 32'(e.rx));
                check("latency1", 32'(cyc - e.t0), 32'(16 * DIV1 + 1));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic issue0(input logic [7:0] tx, input logic [7:0] resp, input bit track);
        exp_t e;
        resp_next = resp;
        tx_data0  = tx;
        start0    = 1'b1;
        e.rx = resp;
        e.tx = tx;
        e.t0 = cyc;
        if (track) q0.push_back(e);
        step(1);
        start0   = 1'b0;
        tx_data0 = ~tx;
    endtask

    task automatic issue1(input logic [7:0] tx);
        exp_t e;
        tx_data1 = tx;
        start1   = 1'b1;
        e.rx = tx;
        e.tx = tx;
        e.t0 = cyc;
        q1.push_back(e);
        step(1);
        start1   = 1'b0;
        tx_data1 = ~tx;
    endtask

    task automatic wait_done0(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done0_timeout: got no done in %0d cycles, expected one", budget);
        end
        #1;
    endtask

    task automatic wait_done1(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done1) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done1_timeout: got no done in %0d cycles, expected one", budget);
        end
        #1;
    endtask

    initial begin
        int  base;
        int  base_ss;
        bit  reached;
        rst_n    = 1'b0;
        start0   = 1'b0;
        hold0    = 1'b0;
        tx_data0 = 8'h00;
        start1   = 1'b0;
        hold1    = 1'b0;
        tx_data1 = 8'h00;

        // Reset and idle behaviour.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1);
        check("reset_sclk", 32'(sclk0), 32'd0);
        check("reset_ss", 32'(ss0), 32'd0);
        check("reset_mosi", 32'(mosi0), 32'd0);
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_done", 32'(done0), 32'd0);
        check("reset_rx_data", 32'(rx_data0), 32'h00);
        base = rises0;
        step(20);
        check("idle_no_sclk", 32'(rises0 - base), 32'd0);
        check("idle_ss_low", 32'(ss0), 32'd0);

        // Single byte, SS released after the transfer.
        issue0(8'h6A, 8'h95, 1'b1);
        check("busy_after_start", 32'(busy0), 32'd1);
        check("ss_after_start", 32'(ss0), 32'd1);
        wait_done0(200);
        step(1);
        check("ss_low_after_done", 32'(ss0), 32'd0);
        step(3);

        // Two-byte frame with SS held, second start in the done cycle.
        hold0 = 1'b1;
        issue0(8'h91, 8'h95, 1'b1);
        base_ss = ss_low_cnt0;
        wait_done0(200);
        issue0(8'h92, 8'h92, 1'b1);
        wait_done0(200);
        step(3);
        check("ss_held_in_frame", 32'(ss_low_cnt0 - base_ss), 32'd0);
        hold0 = 1'b0;
        step(1);
        check("ss_release", 32'(ss0), 32'd0);
        step(2);

        // A start during a transfer is neither honoured nor queued.
        base = done_cnt0;
        issue0(8'h00, 8'($urandom), 1'b1);
        step(6);
        tx_data0 = 8'hFF;
        start0   = 1'b1;
        step(1);
        start0   = 1'b0;
        wait_done0(200);
        step(40);
        check("single_done_busy_reject", 32'(done_cnt0 - base), 32'd1);

        // Reset in the middle of a byte.
        base    = done_cnt0;
        reached = 1'b0;
        issue0(8'hC3, 8'h5A, 1'b0);
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            #1;
            if (rises0 >= 4) reached = 1'b1;
        end
        check("reached_bit4", 32'(reached), 32'd1);
        step(DIV0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_sclk", 32'(sclk0), 32'd0);
        check("midreset_ss", 32'(ss0), 32'd0);
        check("midreset_mosi", 32'(mosi0), 32'd0);
        check("midreset_busy", 32'(busy0), 32'd0);
        check("midreset_done", 32'(done0), 32'd0);
        check("midreset_rx_data", 32'(rx_data0), 32'h00);
        #1 rst_n = 1'b1;
        step(50);
        check("no_done_after_reset", 32'(done_cnt0 - base), 32'd0);
        issue0(8'hA5, 8'($urandom), 1'b1);
        wait_done0(200);
        step(2);

        // Randomised bytes, holds and gaps.
        for (int k = 0; k < 10; k++) begin
            hold0 = 1'($urandom_range(0, 1));
            issue0(8'($urandom), 8'($urandom), 1'b1);
            wait_done0(200);
            if ($urandom_range(0, 1) == 1) step(int'($urandom_range(1, 4)));
        end
        hold0 = 1'b0;
        step(3);
        check("ss_idle_end", 32'(ss0), 32'd0);

        // Fastest SCLK, loopback.
        issue1(8'h3C);
        wait_done1(100);
        for (int k = 0; k < 5; k++) begin
            step(int'($urandom_range(1, 3)));
            issue1(8'($urandom));
            wait_done1(100);
        end
        step(5);
        check("queue0_drained", 32'(q0.size()), 32'd0);
        check("queue1_drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
